// File: rtl/dev_mem_arbiter.sv
// Round-robin request/acknowledge arbiter sharing the device-side memory bus.
// One transaction at a time, with timeout abort on a missing mem_ack.
module dev_mem_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned AW      = 27,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_wdata,
  input  logic [NREQ-1:0]   req_rnw,
  input  logic [NREQ-1:0]   req_sram,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rdata,
  output logic              timeout,
  output logic [AW-1:0]     mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_rnw,
  output logic              mem_ram_cs,
  output logic              mem_sram_cs,
  input  logic [7:0]        mem_q,
  input  logic              mem_ack
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            rnw_q, rnw_d;
  logic            sram_q, sram_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            abort_q, abort_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            timeout_q, timeout_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]      mem_data_q, mem_data_d;
  logic            mem_rnw_q, mem_rnw_d;
  logic            ram_cs_q, ram_cs_d;
  logic            sram_cs_q, sram_cs_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  int unsigned     pidx;

  // First active requester after the last-served one, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(grant_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    pidx = 32'(pick);
  end

  // Next state, transaction latch and registered-output decode.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rnw_d      = rnw_q;
    sram_d     = sram_q;
    cnt_d      = cnt_q;
    abort_d    = abort_q;
    rdata_d    = rdata_q;
    mem_addr_d = '1;
    mem_data_d = 8'hFF;
    mem_rnw_d  = 1'b1;
    ram_cs_d   = 1'b0;
    sram_cs_d  = 1'b0;
    ack_d      = '0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          addr_d  = req_addr[pidx*AW +: AW];
          wdata_d = req_wdata[pidx*8 +: 8];
          rnw_d   = req_rnw[pick];
          sram_d  = req_sram[pick];
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
        // A late mem_ack coinciding with expiry still counts as a completion.
        if (mem_ack) begin
          if (rnw_q) rdata_d = mem_q;
          abort_d = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          if (rnw_q) rdata_d = 8'hFF;
          abort_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == BUSY) begin
      mem_addr_d = addr_d;
      mem_data_d = wdata_d;
      mem_rnw_d  = rnw_d;
      ram_cs_d   = !sram_d;
      sram_cs_d  = sram_d;
    end
    if (state_d == DONE) begin
      for (int unsigned i = 0; i < NREQ; i++) ack_d[i] = (grant_d == IW'(i));
      timeout_d = abort_d;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= IW'(NREQ - 1);
      addr_q     <= '1;
      wdata_q    <= 8'hFF;
      rnw_q      <= 1'b1;
      sram_q     <= 1'b0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      rdata_q    <= 8'hFF;
      ack_q      <= '0;
      timeout_q  <= 1'b0;
      mem_addr_q <= '1;
      mem_data_q <= 8'hFF;
      mem_rnw_q  <= 1'b1;
      ram_cs_q   <= 1'b0;
      sram_cs_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rnw_q      <= rnw_d;
      sram_q     <= sram_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      timeout_q  <= timeout_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_rnw_q  <= mem_rnw_d;
      ram_cs_q   <= ram_cs_d;
      sram_cs_q  <= sram_cs_d;
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign timeout     = timeout_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign mem_rnw     = mem_rnw_q;
  assign mem_ram_cs  = ram_cs_q;
  assign mem_sram_cs = sram_cs_q;

endmodule

// File: tb/tb_dev_mem_arbiter.sv
// Bench for dev_mem_arbiter: vector table plus grant-order, timeout and reset sequences,
// with a memory responder and an ack-driven scoreboard.
module tb_dev_mem_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 27;
  localparam int unsigned TMO  = 255;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   req_rnw;
  logic [NREQ-1:0]   req_sram;
  logic [NREQ-1:0]   ack;
  logic [7:0]        rdata;
  logic              timeout;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_data;
  logic              mem_rnw;
  logic              mem_ram_cs;
  logic              mem_sram_cs;
  logic [7:0]        mem_q;
  logic              mem_ack;

  dev_mem_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rnw(req_rnw), .req_sram(req_sram), .ack(ack),
    .rdata(rdata), .timeout(timeout), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rnw(mem_rnw), .mem_ram_cs(mem_ram_cs), .mem_sram_cs(mem_sram_cs),
    .mem_q(mem_q), .mem_ack(mem_ack)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [1:0]    idx;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          rnw;
    logic          sram;
    int            k;          // cs cycle in which memory acks, 0 = never
    logic [7:0]    mxor;
    logic [7:0]    exp_rdata;
    logic          exp_to;
    int            exp_cs;
  } vec_t;

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          rnw;
    logic          sram;
    logic [7:0]    rdata;
    logic          to;
    int            cs;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int ack_k = 0;
  logic [7:0] mem_xor = 8'h00;
  int mem_cyc = 0;
  int cs_run  = 0;
  int gap     = 0;
  bit gap_armed = 1'b0;
  bit chk_gap   = 1'b0;
  exp_t mon_e;
  logic [NREQ-1:0] oh;

  localparam logic [AW+10:0] IDLE_BUS = {{AW{1'b1}}, 8'hFF, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks in the ack_k-th cs cycle, data = addr[7:0] ^ mem_xor.
  always @(negedge clk_sys) begin
    if (!reset_n || !(mem_ram_cs || mem_sram_cs)) begin
      mem_cyc = 0;
      mem_ack = 1'b0;
      mem_q   = 8'h00;
    end else begin
      mem_cyc++;
      mem_ack = (ack_k != 0) && (mem_cyc == ack_k);
      mem_q   = mem_ack ? (mem_addr[7:0] ^ mem_xor) : 8'h00;
    end
  end

  // Monitor: bus contents while selected, scoreboard pop on ack.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      cs_run    = 0;
      gap_armed = 1'b0;
    end else begin
      if (!chk_gap) gap_armed = 1'b0;
      if (mem_ram_cs || mem_sram_cs) begin
        cs_run++;
        if (gap_armed) begin
          chk("idle_gap_1to2", 64'((gap >= 1) && (gap <= 2)), 64'd1);
          gap_armed = 1'b0;
        end
        if (sb.size() > 0) begin
          mon_e = sb[0];
          chk("busy_bus", {mem_addr, mem_data, mem_rnw, mem_ram_cs, mem_sram_cs},
              {mon_e.addr, mon_e.wdata, mon_e.rnw, !mon_e.sram, mon_e.sram});
        end
      end else if (gap_armed) begin
        gap++;
      end
      if (ack == '0) begin
        chk("timeout_without_ack", 64'(timeout), 64'd0);
      end else if (sb.size() == 0) begin
        chk("unexpected_ack", 64'(ack), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        oh = '0;
        oh[mon_e.idx] = 1'b1;
        chk("ack_grant", 64'(ack), 64'(oh));
        chk("rdata", 64'(rdata), 64'(mon_e.rdata));
        chk("timeout_pulse", 64'(timeout), 64'(mon_e.to));
        chk("cs_cycles", 64'(cs_run), 64'(mon_e.cs));
        chk("done_bus_idle", {mem_addr, mem_data, mem_rnw, mem_ram_cs, mem_sram_cs}, IDLE_BUS);
        cs_run = 0;
        if (chk_gap) begin
          gap_armed = 1'b1;
          gap = 1;
        end
      end
    end
  end

  task automatic wait_acks(input int n, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk_sys);
      if (ack != '0) begin
        seen++;
        if (seen == n) req = '0;
      end
    end
    chk("ack_count", 64'(seen), 64'(n));
    if (seen < n) begin
      sb.delete();
      req = '0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    @(negedge clk_sys);
    ack_k   = v.k;
    mem_xor = v.mxor;
    req_addr[v.idx*AW +: AW] = v.addr;
    req_wdata[v.idx*8 +: 8]  = v.wdata;
    req_rnw[v.idx]  = v.rnw;
    req_sram[v.idx] = v.sram;
    e = '{int'(v.idx), v.addr, v.wdata, v.rnw, v.sram, v.exp_rdata, v.exp_to, v.exp_cs};
    sb.push_back(e);
    req = '0;
    req[v.idx] = 1'b1;
    wait_acks(1, 600);
  endtask

  vec_t tbl[6];
  exp_t e;

  initial begin
    tbl[0] = '{2'd0, 27'h0123456, 8'h00, 1'b1, 1'b0, 2,   8'h0C, 8'h5A, 1'b0, 2};
    tbl[1] = '{2'd1, 27'h7FEDCBA, 8'hC3, 1'b0, 1'b1, 3,   8'h00, 8'h5A, 1'b0, 3};
    tbl[2] = '{2'd2, 27'h0000100, 8'h11, 1'b1, 1'b0, 0,   8'h00, 8'hFF, 1'b1, 255};
    tbl[3] = '{2'd2, 27'h1234577, 8'h22, 1'b1, 1'b1, 255, 8'h11, 8'h66, 1'b0, 255};
    tbl[4] = '{2'd1, 27'h4000099, 8'h44, 1'b1, 1'b1, 1,   8'h0F, 8'h96, 1'b0, 1};
    tbl[5] = '{2'd2, 27'h0000042, 8'h3C, 1'b0, 1'b0, 1,   8'h00, 8'h96, 1'b0, 1};

    reset_n   = 1'b0;
    req       = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_rnw   = '0;
    req_sram  = '0;
    mem_ack   = 1'b0;
    mem_q     = 8'h00;

    repeat (3) @(negedge clk_sys);
    chk("reset_bus", {mem_addr, mem_data, mem_rnw, mem_ram_cs, mem_sram_cs}, IDLE_BUS);
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_timeout", 64'(timeout), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'hFF);
    reset_n = 1'b1;
    @(negedge clk_sys);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // All three requesting continuously: expect 0,1,2,0,1,2.
    @(negedge clk_sys);
    ack_k   = 1;
    mem_xor = 8'h00;
    chk_gap = 1'b1;
    req_addr  = {27'h0000033, 27'h0000022, 27'h0000011};
    req_wdata = {8'hA2, 8'hA1, 8'hA0};
    req_rnw   = 3'b111;
    req_sram  = 3'b010;
    for (int r = 0; r < 6; r++) begin
      e.idx   = r % 3;
      e.addr  = req_addr[(r % 3)*AW +: AW];
      e.wdata = req_wdata[(r % 3)*8 +: 8];
      e.rnw   = 1'b1;
      e.sram  = req_sram[r % 3];
      e.rdata = e.addr[7:0];
      e.to    = 1'b0;
      e.cs    = 1;
      sb.push_back(e);
    end
    req = 3'b111;
    wait_acks(6, 100);
    chk_gap = 1'b0;

    // Reset in the middle of a requester-1 read abandons it silently.
    @(negedge clk_sys);
    ack_k = 0;
    req_addr[1*AW +: AW] = 27'h0ABCDEF;
    req_wdata[15:8] = 8'h55;
    req_rnw  = 3'b111;
    req_sram = 3'b000;
    e = '{1, 27'h0ABCDEF, 8'h55, 1'b1, 1'b0, 8'hFF, 1'b0, 0};
    sb.push_back(e);
    req = 3'b010;
    repeat (5) @(negedge clk_sys);
    chk("pre_reset_busy", 64'(mem_ram_cs), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset_bus", {mem_addr, mem_data, mem_rnw, mem_ram_cs, mem_sram_cs}, IDLE_BUS);
    chk("midreset_ack", 64'(ack), 64'd0);
    chk("midreset_timeout", 64'(timeout), 64'd0);
    chk("midreset_rdata", 64'(rdata), 64'hFF);
    sb.delete();
    req = '0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // After reset requester 0 has top priority, so 3'b110 grants 1 before 2.
    ack_k = 1;
    mem_xor = 8'h00;
    req_addr[1*AW +: AW] = 27'h0000081;
    req_addr[2*AW +: AW] = 27'h00000C2;
    req_wdata = {8'h62, 8'h61, 8'h60};
    e = '{1, 27'h0000081, 8'h61, 1'b1, 1'b0, 8'h81, 1'b0, 1};
    sb.push_back(e);
    e = '{2, 27'h00000C2, 8'h62, 1'b1, 1'b0, 8'hC2, 1'b0, 1};
    sb.push_back(e);
    req = 3'b110;
    wait_acks(2, 100);

    repeat (3) @(negedge clk_sys);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
